// File: rtl/clock_timer_interrupt_pkg.sv
// Clock-timer interrupt factor definitions.
// The timer, stopwatch consumer and CPU I/O decoder share these.
package clock_timer_interrupt_pkg;

   localparam int IT32_BIT    = 0;
   localparam int IT8_BIT     = 1;
   localparam int IT2_BIT     = 2;
   localparam int IT1_BIT     = 3;
   localparam int NUM_SOURCES = 4;

   typedef logic [NUM_SOURCES-1:0] clock_factor_t;

   // Gathers the divider taps into factor bit order.
   function automatic clock_factor_t pack_sources(input logic t32, input logic t8,
                                                  input logic t2, input logic t1);
      clock_factor_t v;
      v           = '0;
      v[IT32_BIT] = t32;
      v[IT8_BIT]  = t8;
      v[IT2_BIT]  = t2;
      v[IT1_BIT]  = t1;
      return v;
   endfunction

endpackage

// File: rtl/fall_detect.sv
// Single-source 1->0 detector; fall is combinational from the registered previous value.
// No backpressure; suppress masks falls in its own cycle and the cycle after it.
module fall_detect (
   input  logic clk,
   input  logic reset_n,
   input  logic in,
   input  logic suppress,
   output logic fall
);

   logic prev;
   logic suppress_d;

   // prev follows the input every cycle, so it already holds the post-reset
   // value of the timer once suppression ends.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev       <= 1'b0;
         suppress_d <= 1'b0;
      end else begin
         prev       <= in;
         suppress_d <= suppress;
      end
   end

   assign fall = prev & ~in & ~(suppress | suppress_d);

endmodule

// File: rtl/clock_timer_interrupt.sv
// Latches 32/8/2/1 Hz divider falls into sticky factor flags; irq = |(factor & mask), flags visible one cycle after the fall.
// No backpressure; a fall always sets its flag even when a clear lands in the same cycle.
module clock_timer_interrupt
   import clock_timer_interrupt_pkg::*;
#(
   parameter logic [3:0] RESET_MASK    = 4'b0000,
   parameter bit         CLEAR_ON_READ = 1'b1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       timer_32hz,
   input  logic       timer_8hz,
   input  logic       timer_2hz,
   input  logic       timer_1hz,
   input  logic       reset_clock_timer,
   input  logic       read_factor,
   input  logic       clear_factor,
   input  logic       write_mask,
   input  logic [3:0] mask_wdata,
   output logic [3:0] factor,
   output logic [3:0] mask,
   output logic       irq
);

   clock_factor_t sources;
   clock_factor_t falls;
   clock_factor_t factor_q;
   clock_factor_t factor_next;
   clock_factor_t mask_q;
   logic          clear_all;

   assign sources = pack_sources(timer_32hz, timer_8hz, timer_2hz, timer_1hz);

   for (genvar i = 0; i < NUM_SOURCES; i++) begin : g_src
      fall_detect u_fall_detect (
         .clk      (clk),
         .reset_n  (reset_n),
         .in       (sources[i]),
         .suppress (reset_clock_timer),
         .fall     (falls[i])
      );
   end

   // The CPU samples factor during the read cycle, so clearing at the end of
   // that cycle loses nothing; OR-ing falls after the clear keeps new events.
   always_comb begin
      clear_all   = clear_factor | (CLEAR_ON_READ & read_factor);
      factor_next = (clear_all ? '0 : factor_q) | falls;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         factor_q <= '0;
         mask_q   <= RESET_MASK;
      end else begin
         factor_q <= factor_next;
         if (write_mask) begin
            mask_q <= mask_wdata;
         end
      end
   end

   assign factor = factor_q;
   assign mask   = mask_q;
   assign irq    = |(factor_q & mask_q);

endmodule

// File: tb/tb_clock_timer_interrupt.sv
module tb_clock_timer_interrupt;

   localparam logic [3:0] RST_MASK = 4'b0000;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       t32 = 1'b0, t8 = 1'b0, t2 = 1'b0, t1 = 1'b0;
   logic       rct = 1'b0, rd = 1'b0, clr = 1'b0, wm = 1'b0;
   logic [3:0] wdata = 4'b0000;
   logic [3:0] factor;
   logic [3:0] mask;
   logic       irq;

   always #5 clk = ~clk;

   clock_timer_interrupt #(
      .RESET_MASK    (RST_MASK),
      .CLEAR_ON_READ (1'b1)
   ) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .timer_32hz        (t32),
      .timer_8hz         (t8),
      .timer_2hz         (t2),
      .timer_1hz         (t1),
      .reset_clock_timer (rct),
      .read_factor       (rd),
      .clear_factor      (clr),
      .write_mask        (wm),
      .mask_wdata        (wdata),
      .factor            (factor),
      .mask              (mask),
      .irq               (irq)
   );

   typedef struct {
      logic [3:0] f;
      logic [3:0] m;
      logic       irq;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   passed = 0;
   int   ev[4];

   // Reference state of the interrupt stage.
   logic [3:0] m_prev   = 4'b0000;
   logic [3:0] m_factor = 4'b0000;
   logic [3:0] m_mask   = RST_MASK;
   logic       m_supd   = 1'b0;

   task automatic check4(input string tag, input string what,
                         input logic [3:0] got, input logic [3:0] want);
      checks++;
      assert (got === want) passed++;
      else $error("FAIL %s.%s: got %b want %b", tag, what, got, want);
   endtask

   task automatic check_int(input string tag, input int got, input int want);
      checks++;
      assert (got == want) passed++;
      else $error("FAIL %s: got %0d want %0d", tag, got, want);
   endtask

   // One clock cycle: predict the post-edge state from the currently driven
   // inputs, queue it, then compare after the edge and drop the strobes.
   task automatic tick(input string tag);
      logic [3:0] cur, falls, nf, nm;
      exp_t       e;
      cur   = {t1, t2, t8, t32};
      falls = (rct | m_supd) ? 4'b0000 : (m_prev & ~cur);
      nf    = ((clr | rd) ? 4'b0000 : m_factor) | falls;
      nm    = wm ? wdata : m_mask;
      m_prev   = cur;
      m_supd   = rct;
      m_factor = nf;
      m_mask   = nm;
      exp_q.push_back('{f: nf, m: nm, irq: |(nf & nm)});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check4(tag, "factor", factor, e.f);
      check4(tag, "mask", mask, e.m);
      check4(tag, "irq", {3'b000, irq}, {3'b000, e.irq});
      rd  = 1'b0;
      clr = 1'b0;
      wm  = 1'b0;
      rct = 1'b0;
   endtask

   initial begin
      logic [9:0] v;
      // Reset state
      #2;
      check4("reset", "factor", factor, 4'b0000);
      check4("reset", "mask", mask, RST_MASK);
      check4("reset", "irq", {3'b000, irq}, 4'b0000);
      #10 reset_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: 32 Hz fall sets IT32, masked so no irq
      t32 = 1'b1; tick("t1_hi");
      t32 = 1'b0; tick("t1_fall");
      check4("t1_direct", "factor", factor, 4'b0001);
      clr = 1'b1; tick("t1_clr");

      // 2: unmasked 1 Hz fall, then clear-on-read
      wm = 1'b1; wdata = 4'b1000; tick("t2_mask");
      t1 = 1'b1; tick("t2_hi");
      t1 = 1'b0; tick("t2_fall");
      rd = 1'b1;
      check4("t2_peek", "factor", factor, 4'b1000);
      tick("t2_read");

      // 3: read coinciding with an 8 Hz fall keeps the new flag
      wm = 1'b1; wdata = 4'b0000; tick("t3_unmask");
      t32 = 1'b1; t8 = 1'b1; tick("t3_hi");
      t32 = 1'b0; tick("t3_fall32");
      t8 = 1'b0; rd = 1'b1;
      check4("t3_peek", "factor", factor, 4'b0001);
      tick("t3_read_fall8");
      clr = 1'b1; tick("t3_clr");

      // 4: reset_clock_timer suppresses falls in its cycle and the next
      t2 = 1'b1; tick("t4_hi"); tick("t4_hold");
      rct = 1'b1; t2 = 1'b0; tick("t4_rct_fall");
      t2 = 1'b1; rct = 1'b1; tick("t4_rct_hi");
      t2 = 1'b0; tick("t4_after_fall");
      tick("t4_idle");
      t2 = 1'b1; tick("t4_hi2");
      t2 = 1'b0; tick("t4_real_fall");
      t2 = 1'b1; tick("t4_hi3");
      rct = 1'b1; t2 = 1'b0; tick("t4_flag_kept");
      clr = 1'b1; tick("t4_clr");

      // 5: mask/unmask an already-set flag pair
      t32 = 1'b1; t2 = 1'b1; tick("t5_hi");
      t32 = 1'b0; t2 = 1'b0; tick("t5_fall");
      wm = 1'b1; wdata = 4'b0100; tick("t5_unmask");
      wm = 1'b1; wdata = 4'b0000; tick("t5_mask");
      check4("t5_retained", "factor", factor, 4'b0101);

      // Clear and set in the same cycle: set wins for that bit only
      t32 = 1'b1; tick("sc_hi");
      t32 = 1'b0; clr = 1'b1; tick("sc_fall_clr");
      // Mask write and flag set in the same cycle
      t8 = 1'b1; tick("mw_hi");
      t8 = 1'b0; wm = 1'b1; wdata = 4'b0010; tick("mw_fall_write");
      clr = 1'b1; tick("mw_clr");
      // All four sources fall together
      {t1, t2, t8, t32} = 4'b1111; tick("all_hi");
      {t1, t2, t8, t32} = 4'b0000; tick("all_fall");
      check4("all_direct", "factor", factor, 4'b1111);
      clr = 1'b1; wm = 1'b1; wdata = 4'b1111; tick("all_clr");

      // 6: one emulated second of a free-running divider chain
      for (int k = 0; k < 4; k++) ev[k] = 0;
      for (int c = 0; c <= 1024; c++) begin
         v = 10'(c);
         t32 = v[4]; t8 = v[6]; t2 = v[8]; t1 = v[9];
         tick("run");
         for (int k = 0; k < 4; k++) if (factor[k]) ev[k]++;
         if (factor != 4'b0000) clr = 1'b1;
      end
      tick("run_tail");
      check_int("events_32hz", ev[0], 32);
      check_int("events_8hz", ev[1], 8);
      check_int("events_2hz", ev[2], 2);
      check_int("events_1hz", ev[3], 1);

      // Asynchronous reset with a pending, unmasked flag
      t32 = 1'b1; tick("ar_hi");
      t32 = 1'b0; tick("ar_fall");
      #3 reset_n = 1'b0;
      #1;
      check4("async_reset", "factor", factor, 4'b0000);
      check4("async_reset", "mask", mask, RST_MASK);
      check4("async_reset", "irq", {3'b000, irq}, 4'b0000);
      m_prev = 4'b0000; m_factor = 4'b0000; m_mask = RST_MASK; m_supd = 1'b0;
      @(posedge clk);
      #1 reset_n = 1'b1;
      tick("post_reset");

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/clock_timer_interrupt.md
Name: clock_timer_interrupt

Overview:
Interrupt-factor stage directly downstream of the timer block. It consumes the 32/8/2/1 Hz clock-timer divider outputs and latches a factor flag on each falling edge. Flags are masked by a CPU-written enable register and drive a level interrupt request to the CPU interrupt controller. The factor register clears when the CPU reads it.

Parameters:
RESET_MASK, 4'b0000, mask register value after reset (bit map as factor).
CLEAR_ON_READ, 1, 1 = factor flags clear on read_factor; 0 = flags clear only via clear_factor.

Ports:
clk  input  1  system clock; timer inputs are synchronous to it.
reset_n  input  1  asynchronous active-low reset.
timer_32hz  input  1  32 Hz divider output from the timer block.
timer_8hz  input  1  8 Hz divider output.
timer_2hz  input  1  2 Hz divider output.
timer_1hz  input  1  1 Hz divider output.
reset_clock_timer  input  1  same strobe that resets the timer block; suppresses edge detection.
read_factor  input  1  one-cycle CPU read strobe of the factor register.
clear_factor  input  1  one-cycle explicit clear of all factor flags.
write_mask  input  1  one-cycle CPU write strobe for the mask register.
mask_wdata  input  4  new mask value.
factor  output  4  current factor flags: bit0 IT32, bit1 IT8, bit2 IT2, bit3 IT1.
mask  output  4  current mask register, same bit map as factor.
irq  output  1  interrupt request, level; equals |(factor & mask).

Behaviour:
- Reset (reset_n low, asynchronous):
  - factor = 0, mask = RESET_MASK, irq = 0.
  - All previous-value registers = 0, so no spurious edge fires on reset release.
- Edge detection:
  - Each source keeps a previous-value register.
  - A fall is prev=1 and cur=0 in the same cycle.
  - The previous-value register updates every cycle.
- Flag set:
  - A fall detected in cycle N sets its factor bit at the clk edge ending cycle N.
  - factor is visible in cycle N+1.
  - Flags set regardless of mask.
  - A set flag stays set (sticky) until cleared.
- irq:
  - Combinational from the factor and mask registers.
  - Asserts in cycle N+1 if the mask bit is 1; no further latency.
- Mask write:
  - write_mask in cycle N loads mask_wdata at the end of N.
  - irq reflects the new mask in N+1.
  - Unmasking an already-set flag raises irq immediately (N+1).
  - Masking drops irq in N+1; the flag itself is retained.
- Read:
  - factor is readable combinationally during the read_factor cycle; the CPU samples that value.
  - With CLEAR_ON_READ=1, all flags clear at the end of that cycle.
- clear_factor clears all flags at the end of its cycle; this is independent of CLEAR_ON_READ.
- Simultaneous set and clear in the same cycle: set wins for that bit; other bits clear. A fall is never lost.
- Multiple sources falling in one cycle (e.g. 1 Hz, 2 Hz, 8 Hz and 32 Hz all fall together): all bits set together.
- reset_clock_timer:
  - While it is high, and for the cycle after it, falls are ignored and previous-value registers load the current input values.
  - Existing flags are untouched.
  - This prevents the timer block's counter reset from producing false falls.
- Mask write and flag set in the same cycle: both take effect; irq in N+1 uses the new mask.

Decomposition:
- Shared package (tamagotchi timer package):
  - bit index constants IT32_BIT=0, IT8_BIT=1, IT2_BIT=2, IT1_BIT=3;
  - typedef clock_factor_t = logic [3:0].
  - The timer, stopwatch-consumer and CPU I/O decoder reuse these.
- One sub-module: fall_detect.
  - Ports: clk, reset_n, in, suppress, fall.
  - Instantiated four times.
- The flag, mask and irq logic lives in the top.

Test Plan:
1. Reset with RESET_MASK=0, then drive timer_32hz 1→0 → factor=4'b0001 the next cycle; irq=0.
2. Write mask_wdata=4'b1000, then timer_1hz falls → factor[3]=1 and irq=1 one cycle after the fall; read_factor → factor reads 4'b1000 that cycle, becomes 0 the next, and irq drops.
3. Pulse read_factor in the same cycle as a timer_8hz fall, with factor=4'b0001 beforehand → next cycle factor=4'b0010 (IT32 cleared, IT8 kept).
4. Pulse reset_clock_timer while timer_2hz=1 and the timer block forces it to 0 → factor stays 4'b0000 and no irq.
5. Set factor=4'b0101 with mask=0, then write mask=4'b0100 → irq=1 the following cycle. Write mask=0 → irq=0 and factor is still 4'b0101.
6. Run a free-running timer block for 1 s → exactly 32, 8, 2 and 1 set events for the respective bits, counted with clear_factor after each event; assert reset_n mid-run → factor=0, mask=RESET_MASK, irq=0 asynchronously.
